// File: rtl/cc1200_pkg.sv
// Shared definitions for the CC1200 SPI word scheduler: FSM states, word width, owner encoding.
package cc1200_pkg;

  localparam int unsigned WORD_W = 12;

  localparam logic OWN_CMD   = 1'b0;
  localparam logic OWN_BURST = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLoad,
    StStart,
    StWait,
    StGap
  } state_t;

endpackage

// File: rtl/cc1200_down_cnt.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module cc1200_down_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cc1200_spi_sched.sv
// Arbitrates the burst stream and single register commands onto one SPI word engine and
// sequences each word through load, start, wait-for-done and an inter-word gap.
module cc1200_spi_sched #(
  parameter int unsigned WORD_W    = 12,
  parameter int unsigned GAP_CYC   = 4,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              burst_en,
  input  logic [WORD_W-1:0] burst_data,
  output logic              burst_next,
  input  logic              cmd_req,
  input  logic [WORD_W-1:0] cmd_data,
  output logic              cmd_ack,
  output logic              spi_start,
  output logic [WORD_W-1:0] spi_word,
  input  logic              spi_done,
  output logic              busy,
  output logic              owner,
  output logic [4:0]        word_cnt,
  output logic              err
);

  import cc1200_pkg::*;

  // Gap must cover the 2-cycle test-memory read after each burst_next.
  localparam int unsigned GAP_EFF = (GAP_CYC < 2) ? 2 : GAP_CYC;
  localparam int unsigned GAP_W   = $clog2(GAP_EFF + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);
  localparam logic [4:0]  MAX_CNT = 5'(MAX_BURST);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              err_q, err_d;
  logic              rd_wait_q, rd_wait_d;
  logic [4:0]        word_cnt_q, word_cnt_d;
  logic [WORD_W-1:0] spi_word_q, spi_word_d;

  logic gap_load, gap_dec, gap_zero;
  logic tmo_load, tmo_dec, tmo_zero;

  cc1200_down_cnt #(
    .W (GAP_W)
  ) u_gap_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (gap_load),
    .load_val (GAP_W'(GAP_EFF - 1)),
    .dec      (gap_dec),
    .zero     (gap_zero)
  );

  cc1200_down_cnt #(
    .W (TMO_W)
  ) u_tmo_cnt (
    .clk      (clk),
    .rstn     (rstn),
    .load     (tmo_load),
    .load_val (TMO_W'(TIMEOUT - 1)),
    .dec      (tmo_dec),
    .zero     (tmo_zero)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      owner_q    <= OWN_CMD;
      err_q      <= 1'b0;
      rd_wait_q  <= 1'b0;
      word_cnt_q <= '0;
      spi_word_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      err_q      <= err_d;
      rd_wait_q  <= rd_wait_d;
      word_cnt_q <= word_cnt_d;
      spi_word_q <= spi_word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    err_d      = err_q;
    rd_wait_d  = rd_wait_q;
    word_cnt_d = word_cnt_q;
    spi_word_d = spi_word_q;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    tmo_load   = 1'b0;
    tmo_dec    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_req || burst_en) state_d = StArb;
      end
      StArb: begin
        if (cmd_req) begin
          owner_d = OWN_CMD;
          err_d   = 1'b0;
          state_d = StLoad;
        end else if (burst_en) begin
          owner_d    = OWN_BURST;
          err_d      = 1'b0;
          word_cnt_d = '0;
          rd_wait_d  = 1'b1;
          state_d    = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      StLoad: begin
        // A fresh burst grant spends one extra cycle so the first memory read has landed.
        if (owner_q == OWN_CMD) begin
          spi_word_d = cmd_data;
          state_d    = StStart;
        end else if (rd_wait_q) begin
          rd_wait_d = 1'b0;
        end else begin
          spi_word_d = burst_data;
          state_d    = StStart;
        end
      end
      StStart: begin
        tmo_load = 1'b1;
        state_d  = StWait;
      end
      StWait: begin
        if (spi_done) begin
          gap_load = 1'b1;
          state_d  = StGap;
          if ((owner_q == OWN_BURST) && (word_cnt_q < MAX_CNT)) begin
            word_cnt_d = word_cnt_q + 5'd1;
          end
        end else if (tmo_zero) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_dec = 1'b1;
        end
      end
      StGap: begin
        if (!gap_zero) begin
          gap_dec = 1'b1;
        end else if ((owner_q == OWN_BURST) && burst_en && (word_cnt_q < MAX_CNT)) begin
          state_d = StLoad;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy       = (state_q != StIdle);
  assign spi_start  = (state_q == StStart);
  assign cmd_ack    = (state_q == StWait) && spi_done && (owner_q == OWN_CMD);
  assign burst_next = (state_q == StWait) && spi_done && (owner_q == OWN_BURST);
  assign spi_word   = spi_word_q;
  assign owner      = owner_q;
  assign word_cnt   = word_cnt_q;
  assign err        = err_q;

endmodule
